multi_timer: RTL and testbench

Multi-channel, run-time programmable microsecond timer, the parametrised successor to the single-channel fixed-period timer. Each of `CH_NUM` independent channels is started, stopped or restarted by a per-channel request. Each channel runs a period given in microseconds on an input port, in one-shot or periodic mode, and emits a one-cycle expiry pulse. It sits beside control FSMs that need timeouts, poll intervals or delay triggers, so that each user does not need its own timer instance.

---
 rtl/multi_timer.sv | 148 ++++++++++++++
 tb/tb_multi_timer.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/multi_timer.sv
// Multi-channel run-time programmable microsecond timer.
// Each channel runs IDLE/RUN/DONE with one-shot or periodic reload and a one-cycle expiry pulse.
module multi_timer #(
  parameter int CLK_FRE = 50,
  parameter int CH_NUM  = 4,
  parameter int CNT_W   = 32
) (
  input  logic                      I_Clk,
  input  logic                      I_rst_n,
  input  logic [CH_NUM-1:0]         I_ch_start,
  input  logic [CH_NUM-1:0]         I_ch_stop,
  input  logic [CH_NUM-1:0]         I_ch_mode,
  input  logic [CH_NUM*CNT_W-1:0]   I_ch_period_us,
  output logic [CH_NUM-1:0]         O_ch_busy,
  output logic [CH_NUM-1:0]         O_ch_ack,
  output logic [CH_NUM-1:0]         O_ch_done,
  output logic                      O_any_ack
);

  localparam int                CW      = (CLK_FRE > 1) ? $clog2(CLK_FRE) : 1;
  localparam logic [CW-1:0]     CLK_MAX = CW'(CLK_FRE - 1);
  localparam logic [CW-1:0]     CLK_ONE = CW'(1);
  localparam logic [CNT_W-1:0]  US_ONE  = CNT_W'(1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } ch_state_e;

  ch_state_e          state_q   [CH_NUM];
  ch_state_e          state_d   [CH_NUM];
  logic [CW-1:0]      clk_cnt_q [CH_NUM];
  logic [CW-1:0]      clk_cnt_d [CH_NUM];
  logic [CNT_W-1:0]   us_cnt_q  [CH_NUM];
  logic [CNT_W-1:0]   us_cnt_d  [CH_NUM];
  logic [CNT_W-1:0]   per_q     [CH_NUM];
  logic [CNT_W-1:0]   per_d     [CH_NUM];
  logic [CNT_W-1:0]   per_in_s  [CH_NUM];
  logic [CH_NUM-1:0]  mode_q, mode_d;
  logic [CH_NUM-1:0]  expire_s;
  logic [CH_NUM-1:0]  ack_d, busy_d, done_d;
  logic [CH_NUM-1:0]  ack_q, busy_q, done_q;
  logic               any_ack_q;

  // Unpack requested periods (0 maps to 1 us) and detect terminal count per channel.
  always_comb begin
    for (int i = 0; i < CH_NUM; i++) begin
      per_in_s[i] = (I_ch_period_us[i*CNT_W +: CNT_W] == {CNT_W{1'b0}}) ?
                    US_ONE : I_ch_period_us[i*CNT_W +: CNT_W];
      expire_s[i] = (state_q[i] == ST_RUN) && (clk_cnt_q[i] == CLK_MAX) &&
                    (us_cnt_q[i] == (per_q[i] - US_ONE));
    end
  end

  // Per-channel next state: stop beats start beats expiry.
  always_comb begin
    mode_d = mode_q;
    ack_d  = {CH_NUM{1'b0}};
    busy_d = {CH_NUM{1'b0}};
    done_d = {CH_NUM{1'b0}};
    for (int i = 0; i < CH_NUM; i++) begin
      state_d[i]   = state_q[i];
      clk_cnt_d[i] = clk_cnt_q[i];
      us_cnt_d[i]  = us_cnt_q[i];
      per_d[i]     = per_q[i];
      if (I_ch_stop[i]) begin
        state_d[i]   = ST_IDLE;
        clk_cnt_d[i] = {CW{1'b0}};
        us_cnt_d[i]  = {CNT_W{1'b0}};
      end else if (I_ch_start[i]) begin
        state_d[i]   = ST_RUN;
        clk_cnt_d[i] = {CW{1'b0}};
        us_cnt_d[i]  = {CNT_W{1'b0}};
        per_d[i]     = per_in_s[i];
        mode_d[i]    = I_ch_mode[i];
      end else begin
        case (state_q[i])
          ST_RUN: begin
            if (expire_s[i]) begin
              ack_d[i]     = 1'b1;
              clk_cnt_d[i] = {CW{1'b0}};
              us_cnt_d[i]  = {CNT_W{1'b0}};
              if (mode_q[i]) begin
                // Periodic reload picks up the current period and mode with no gap cycle.
                state_d[i] = ST_RUN;
                per_d[i]   = per_in_s[i];
                mode_d[i]  = I_ch_mode[i];
              end else begin
                state_d[i] = ST_DONE;
              end
            end else if (clk_cnt_q[i] == CLK_MAX) begin
              clk_cnt_d[i] = {CW{1'b0}};
              us_cnt_d[i]  = us_cnt_q[i] + US_ONE;
            end else begin
              clk_cnt_d[i] = clk_cnt_q[i] + CLK_ONE;
            end
          end
          ST_IDLE, ST_DONE: begin
            state_d[i] = state_q[i];
          end
          default: begin
            state_d[i]   = ST_IDLE;
            clk_cnt_d[i] = {CW{1'b0}};
            us_cnt_d[i]  = {CNT_W{1'b0}};
          end
        endcase
      end
      busy_d[i] = (state_d[i] == ST_RUN);
      done_d[i] = (state_d[i] == ST_DONE);
    end
  end

  // Channel state, counters, latched period/mode and registered outputs.
  always_ff @(posedge I_Clk or negedge I_rst_n) begin
    if (!I_rst_n) begin
      for (int i = 0; i < CH_NUM; i++) begin
        state_q[i]   <= ST_IDLE;
        clk_cnt_q[i] <= {CW{1'b0}};
        us_cnt_q[i]  <= {CNT_W{1'b0}};
        per_q[i]     <= {CNT_W{1'b0}};
      end
      mode_q    <= {CH_NUM{1'b0}};
      ack_q     <= {CH_NUM{1'b0}};
      busy_q    <= {CH_NUM{1'b0}};
      done_q    <= {CH_NUM{1'b0}};
      any_ack_q <= 1'b0;
    end else begin
      for (int i = 0; i < CH_NUM; i++) begin
        state_q[i]   <= state_d[i];
        clk_cnt_q[i] <= clk_cnt_d[i];
        us_cnt_q[i]  <= us_cnt_d[i];
        per_q[i]     <= per_d[i];
      end
      mode_q    <= mode_d;
      ack_q     <= ack_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      any_ack_q <= |ack_d;
    end
  end

  assign O_ch_busy = busy_q;
  assign O_ch_ack  = ack_q;
  assign O_ch_done = done_q;
  assign O_any_ack = any_ack_q;

endmodule

// File: tb/tb_multi_timer.sv
// Scoreboard bench for multi_timer: stimulus pushes expected ack edges, a monitor checks every ack.
module tb_multi_timer;

  localparam int CLK_FRE = 4;
  localparam int CH_NUM  = 4;
  localparam int CNT_W   = 4;

  logic                    I_Clk;
  logic                    I_rst_n;
  logic [CH_NUM-1:0]       I_ch_start;
  logic [CH_NUM-1:0]       I_ch_stop;
  logic [CH_NUM-1:0]       I_ch_mode;
  logic [CH_NUM*CNT_W-1:0] I_ch_period_us;
  logic [CH_NUM-1:0]       O_ch_busy;
  logic [CH_NUM-1:0]       O_ch_ack;
  logic [CH_NUM-1:0]       O_ch_done;
  logic                    O_any_ack;

  multi_timer #(.CLK_FRE(CLK_FRE), .CH_NUM(CH_NUM), .CNT_W(CNT_W)) dut (
    .I_Clk          (I_Clk),
    .I_rst_n        (I_rst_n),
    .I_ch_start     (I_ch_start),
    .I_ch_stop      (I_ch_stop),
    .I_ch_mode      (I_ch_mode),
    .I_ch_period_us (I_ch_period_us),
    .O_ch_busy      (O_ch_busy),
    .O_ch_ack       (O_ch_ack),
    .O_ch_done      (O_ch_done),
    .O_any_ack      (O_any_ack)
  );

  typedef struct {
    int         e;
    logic [3:0] v;
  } exp_t;

  exp_t qexp[$];
  int   total = 0;
  int   bad   = 0;
  int   edge_n = 0;
  int   k;

  initial begin
    I_Clk = 1'b0;
    forever #5 I_Clk = ~I_Clk;
  end

  always @(posedge I_Clk) edge_n <= edge_n + 1;

  // Insert an expected ack in edge order, merging coincident channels.
  function automatic void push_exp(input int e, input logic [3:0] v);
    exp_t item;
    item.e = e;
    item.v = v;
    for (int j = 0; j < qexp.size(); j++) begin
      if (qexp[j].e == e) begin
        qexp[j].v = qexp[j].v | v;
        return;
      end
      if (qexp[j].e > e) begin
        qexp.insert(j, item);
        return;
      end
    end
    qexp.push_back(item);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (edge %0d)", name, act, exp, edge_n);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge I_Clk);
  endtask

  // Apply start/stop for exactly one edge; k returns that edge's number.
  task automatic pulse(input logic [3:0] st, input logic [3:0] sp, output int kk);
    I_ch_start = st;
    I_ch_stop  = sp;
    kk = edge_n + 1;
    @(negedge I_Clk);
    I_ch_start = 4'b0000;
    I_ch_stop  = 4'b0000;
  endtask

  task automatic set_ch(input int ch, input logic [3:0] per, input logic mode);
    I_ch_period_us[ch*CNT_W +: CNT_W] = per;
    I_ch_mode[ch] = mode;
  endtask

  // Monitor: every presented ack must match the head of the scoreboard.
  always @(negedge I_Clk) begin
    while (qexp.size() > 0 && qexp[0].e < edge_n) begin
      total++;
      bad++;
      $display("FAIL missed_ack: edge %0d expected ack %b got none", qexp[0].e, qexp[0].v);
      void'(qexp.pop_front());
    end
    if (O_ch_ack != 4'b0000 || O_any_ack) begin
      total++;
      if (qexp.size() == 0 || qexp[0].e != edge_n) begin
        bad++;
        $display("FAIL spurious_ack: edge %0d got ack %b any %b, none expected", edge_n, O_ch_ack, O_any_ack);
      end else begin
        if (qexp[0].v !== O_ch_ack || O_any_ack !== (|qexp[0].v)) begin
          bad++;
          $display("FAIL ack_bits: edge %0d got ack %b any %b expected ack %b", edge_n, O_ch_ack, O_any_ack, qexp[0].v);
        end
        void'(qexp.pop_front());
      end
    end
  end

  initial begin
    I_rst_n        = 1'b0;
    I_ch_start     = 4'b0000;
    I_ch_stop      = 4'b0000;
    I_ch_mode      = 4'b0000;
    I_ch_period_us = 16'h0000;
    tick(3);
    check("rst_busy", 32'(O_ch_busy), 32'h0);
    check("rst_done", 32'(O_ch_done), 32'h0);
    check("rst_any",  32'(O_any_ack), 32'h0);
    I_rst_n = 1'b1;
    tick(2);

    // One-shot basic
    set_ch(0, 4'd3, 1'b0);
    pulse(4'b0001, 4'b0000, k);
    push_exp(k + 12, 4'b0001);
    check("os_busy_start", 32'(O_ch_busy[0]), 32'h1);
    tick(11);
    check("os_busy_before", 32'(O_ch_busy[0]), 32'h1);
    check("os_done_before", 32'(O_ch_done[0]), 32'h0);
    tick(1);
    check("os_busy_expire", 32'(O_ch_busy[0]), 32'h0);
    check("os_done_expire", 32'(O_ch_done[0]), 32'h1);
    tick(5);
    check("os_done_hold", 32'(O_ch_done[0]), 32'h1);
    pulse(4'b0000, 4'b0001, k);
    check("os_done_stop", 32'(O_ch_done[0]), 32'h0);

    // Periodic with on-the-fly period change
    set_ch(1, 4'd2, 1'b1);
    pulse(4'b0010, 4'b0000, k);
    push_exp(k + 8, 4'b0010);
    push_exp(k + 16, 4'b0010);
    push_exp(k + 36, 4'b0010);
    tick(11);
    set_ch(1, 4'd5, 1'b1);
    tick(25);
    check("per_busy", 32'(O_ch_busy[1]), 32'h1);
    pulse(4'b0000, 4'b0010, k);
    check("per_stop_busy", 32'(O_ch_busy[1]), 32'h0);

    // Restart discards pending expiry
    set_ch(2, 4'd2, 1'b0);
    pulse(4'b0100, 4'b0000, k);
    tick(6);
    pulse(4'b0100, 4'b0000, k);
    push_exp(k + 8, 4'b0100);
    tick(8);
    check("rs_done", 32'(O_ch_done[2]), 32'h1);
    check("rs_busy", 32'(O_ch_busy[2]), 32'h0);

    // Stop coinciding with expiry
    pulse(4'b0100, 4'b0000, k);
    tick(7);
    pulse(4'b0000, 4'b0100, k);
    check("se_busy", 32'(O_ch_busy[2]), 32'h0);
    check("se_done", 32'(O_ch_done[2]), 32'h0);
    tick(4);

    // Stop and start together
    pulse(4'b0100, 4'b0100, k);
    check("ss_busy", 32'(O_ch_busy[2]), 32'h0);
    check("ss_done", 32'(O_ch_done[2]), 32'h0);
    tick(12);

    // Zero period acts as 1 us
    set_ch(3, 4'd0, 1'b0);
    pulse(4'b1000, 4'b0000, k);
    push_exp(k + 4, 4'b1000);
    tick(4);
    check("zp_done", 32'(O_ch_done[3]), 32'h1);
    pulse(4'b0000, 4'b1000, k);

    // Maximum period, periodic, no overflow
    set_ch(0, 4'd15, 1'b1);
    pulse(4'b0001, 4'b0000, k);
    push_exp(k + 60, 4'b0001);
    push_exp(k + 120, 4'b0001);
    tick(120);
    pulse(4'b0000, 4'b0001, k);
    check("wrap_busy", 32'(O_ch_busy[0]), 32'h0);

    // Concurrent channels
    set_ch(0, 4'd1, 1'b0);
    set_ch(1, 4'd2, 1'b0);
    set_ch(2, 4'd3, 1'b0);
    set_ch(3, 4'd1, 1'b0);
    pulse(4'b1111, 4'b0000, k);
    push_exp(k + 4, 4'b1001);
    push_exp(k + 8, 4'b0010);
    push_exp(k + 12, 4'b0100);
    check("mc_busy", 32'(O_ch_busy), 32'hf);
    tick(12);
    check("mc_done", 32'(O_ch_done), 32'hf);
    check("mc_busy_end", 32'(O_ch_busy), 32'h0);
    pulse(4'b0000, 4'b1111, k);

    // Asynchronous reset mid-run
    set_ch(0, 4'd2, 1'b1);
    pulse(4'b0001, 4'b0000, k);
    tick(3);
    I_rst_n = 1'b0;
    #1;
    check("ar_busy", 32'(O_ch_busy), 32'h0);
    check("ar_done", 32'(O_ch_done), 32'h0);
    check("ar_ack",  32'(O_ch_ack),  32'h0);
    check("ar_any",  32'(O_any_ack), 32'h0);
    tick(2);
    I_rst_n = 1'b1;
    tick(20);
    check("ar_idle_busy", 32'(O_ch_busy), 32'h0);
    set_ch(1, 4'd1, 1'b0);
    pulse(4'b0010, 4'b0000, k);
    push_exp(k + 4, 4'b0010);
    tick(6);
    check("sb_empty", 32'(qexp.size()), 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
